run_ctrl: RTL and testbench

- Parametrised run controller that sits beside the processor skeleton. It sequences core reset and enforces a cycle budget.
- It stretches core reset for a configurable number of cycles. It then runs the core for a loadable number of cycles, supports pause and early halt, and reports completion with a sticky done flag and a cycle count.
- This block makes that sequencing synthesizable and reusable: fixed reset length, fixed run length, single mode become parameters and runtime inputs.

---
 rtl/run_ctrl_pkg.sv | 16 +
 rtl/run_ctrl_if.sv | 38 +++
 rtl/run_ctrl_hold_cnt.sv | 30 +++
 rtl/run_ctrl.sv | 105 ++++++++++
 tb/tb_run_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and default constants for the run controller.
// State encoding is fixed at 3 bits; unused codes recover to HOLD.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    HOLD   = 3'd0,
    IDLE   = 3'd1,
    RUN    = 3'd2,
    PAUSED = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int DEF_RESET_CYCLES = 2;
  localparam int DEF_CNT_W        = 32;

endpackage

// File: rtl/run_ctrl_if.sv
// Control/status bundle between a host (master) and the run controller (slave).
// pause_count exists only when RUN_CTRL_PAUSE_COUNT_EN is defined.
interface run_ctrl_if
  import run_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             start;
  logic [CNT_W-1:0] budget;
  logic             pause;
  logic             halt_req;
  logic             core_reset;
  logic             running;
  logic             done;
  logic             halted;
  logic [CNT_W-1:0] cycle_count;
`ifdef RUN_CTRL_PAUSE_COUNT_EN
  logic [CNT_W-1:0] pause_count;
`endif

  modport master (
`ifdef RUN_CTRL_PAUSE_COUNT_EN
    input  pause_count,
`endif
    output start, budget, pause, halt_req,
    input  core_reset, running, done, halted, cycle_count
  );

  modport slave (
`ifdef RUN_CTRL_PAUSE_COUNT_EN
    output pause_count,
`endif
    input  start, budget, pause, halt_req,
    output core_reset, running, done, halted, cycle_count
  );

endinterface

// File: rtl/run_ctrl_hold_cnt.sv
// Core-reset stretch counter: counts up while not cleared and flags the last
// cycle of the hold window; parks on terminal count until cleared.
module run_ctrl_hold_cnt
  import run_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tc
);

  localparam int W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(RESET_CYCLES - 1);

  logic [W-1:0] hold_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      hold_cnt <= '0;
    else if (clear)
      hold_cnt <= '0;
    else if (!tc)
      hold_cnt <= hold_cnt + W'(1);
  end

  assign tc = (hold_cnt == LAST);

endmodule

// File: rtl/run_ctrl.sv
// Run controller: stretches core reset, then runs the core for a loaded cycle
// budget with pause/halt, reporting a sticky done flag. Optional: RUN_CTRL_PAUSE_COUNT_EN.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic   clock,
  input  logic   reset,
  run_ctrl_if.slave bus
);

  state_t           state, state_nxt;
  logic             hold_tc;
  logic             last_cycle;
  logic             count_en;
  logic [CNT_W-1:0] budget_q;
  logic [CNT_W-1:0] cycle_count;
  logic             halted;

  // Counter is held at zero outside HOLD so every entry starts a full window.
  run_ctrl_hold_cnt #(.RESET_CYCLES(RESET_CYCLES)) u_hold_cnt (
    .clock (clock),
    .reset (reset),
    .clear (state != HOLD),
    .tc    (hold_tc)
  );

  assign last_cycle = (cycle_count + CNT_W'(1)) == budget_q;
  assign count_en   = bus.halt_req || last_cycle || !bus.pause;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= HOLD;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HOLD:   if (hold_tc) state_nxt = IDLE;
      IDLE:   if (bus.start) state_nxt = (bus.budget == '0) ? DONE : RUN;
      RUN: begin
        if (bus.halt_req || last_cycle) state_nxt = DONE;
        else if (bus.pause)             state_nxt = PAUSED;
      end
      PAUSED: begin
        if (bus.halt_req)    state_nxt = DONE;
        else if (!bus.pause) state_nxt = RUN;
      end
      DONE:   if (bus.start) state_nxt = HOLD;
      default: state_nxt = HOLD;
    endcase
  end

  always_comb begin
    bus.core_reset = (state == HOLD);
    bus.running    = (state == RUN);
    bus.done       = (state == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      budget_q    <= '0;
      cycle_count <= '0;
      halted      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          budget_q    <= bus.budget;
          cycle_count <= '0;
          halted      <= 1'b0;
        end
        RUN: begin
          if (count_en)     cycle_count <= cycle_count + CNT_W'(1);
          if (bus.halt_req) halted <= 1'b1;
        end
        PAUSED: if (bus.halt_req) halted <= 1'b1;
        DONE:   if (bus.start) halted <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.cycle_count = cycle_count;
  assign bus.halted      = halted;

`ifdef RUN_CTRL_PAUSE_COUNT_EN
  logic [CNT_W-1:0] pause_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      pause_count <= '0;
    else if (state == IDLE && bus.start)
      pause_count <= '0;
    else if (state == PAUSED && pause_count != '1)
      pause_count <= pause_count + CNT_W'(1);
  end

  assign bus.pause_count = pause_count;
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: event-level reference model checked every cycle,
// plus literal expectations pinning reset, budget, pause, halt and restart behaviour.
module tb_run_ctrl;
  import run_ctrl_pkg::*;

  localparam int RC = 2;
  localparam int W  = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  run_ctrl_if #(.CNT_W(W)) bus ();

  run_ctrl #(.RESET_CYCLES(RC), .CNT_W(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks remaining reset-hold cycles and whether a run is
  // active/paused/finished, using plain counters rather than a state machine.
  int     m_hold_left;
  bit     m_active, m_paused, m_done, m_halted;
  longint m_budget, m_count, m_pcount;
  longint MAXV = (64'd1 << W) - 1;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_hold_left = RC; m_active = 0; m_paused = 0; m_done = 0; m_halted = 0;
      m_budget = 0; m_count = 0; m_pcount = 0;
    end else if (m_hold_left > 0) begin
      m_hold_left--;
    end else if (m_done) begin
      if (bus.start) begin m_done = 0; m_halted = 0; m_hold_left = RC; end
    end else if (!m_active) begin
      if (bus.start) begin
        m_budget = bus.budget; m_count = 0; m_halted = 0; m_pcount = 0;
        if (bus.budget == 0) m_done = 1; else begin m_active = 1; m_paused = 0; end
      end
    end else if (m_paused) begin
      if (m_pcount < MAXV) m_pcount++;
      if (bus.halt_req) begin m_halted = 1; m_done = 1; m_active = 0; m_paused = 0; end
      else if (!bus.pause) m_paused = 0;
    end else begin
      if (bus.halt_req) begin m_count++; m_halted = 1; m_done = 1; m_active = 0; end
      else if (m_count + 1 == m_budget) begin m_count++; m_done = 1; m_active = 0; end
      else if (bus.pause) m_paused = 1;
      else m_count++;
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      check("core_reset", bus.core_reset, m_hold_left > 0);
      check("running", bus.running, m_active && !m_paused);
      check("done", bus.done, m_done);
      check("halted", bus.halted, m_halted);
      check("cycle_count", bus.cycle_count, m_count);
`ifdef RUN_CTRL_PAUSE_COUNT_EN
      check("pause_count", bus.pause_count, m_pcount);
`endif
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, ".core_reset"}, bus.core_reset, 1);
    check({tag, ".running"}, bus.running, 0);
    check({tag, ".done"}, bus.done, 0);
    check({tag, ".halted"}, bus.halted, 0);
    check({tag, ".cycle_count"}, bus.cycle_count, 0);
  endtask

  // Leaves the bench at the first negedge after start was accepted.
  task automatic start_run(input logic [W-1:0] b);
    @(negedge clock); bus.start = 1'b1; bus.budget = b;
    @(negedge clock); bus.start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int run_cyc);
    run_cyc = 0;
    for (int i = 0; i < limit; i++) begin
      if (bus.done) return;
      if (bus.running) run_cyc++;
      @(negedge clock);
    end
    check("wait_done timeout", 0, 1);
  endtask

  task automatic wait_count(input logic [W-1:0] target, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (bus.cycle_count == target) return;
      @(negedge clock);
    end
    check("wait_count timeout", bus.cycle_count, target);
  endtask

  // DONE -> HOLD for RC cycles -> IDLE, checking the re-pulsed core reset.
  task automatic restart(input string tag);
    @(negedge clock); bus.start = 1'b1;
    @(negedge clock); bus.start = 1'b0;
    check({tag, ".rst1"}, bus.core_reset, 1);
    check({tag, ".done_clr"}, bus.done, 0);
    check({tag, ".halted_clr"}, bus.halted, 0);
    @(negedge clock);
    check({tag, ".rst2"}, bus.core_reset, 1);
    @(negedge clock);
    check({tag, ".rst_off"}, bus.core_reset, 0);
  endtask

  initial begin
    int rc;
    bus.start = 1'b0; bus.budget = '0; bus.pause = 1'b0; bus.halt_req = 1'b0;

    repeat (2) @(negedge clock);
    check_reset_values("reset");
    reset = 1'b0;
    @(posedge clock); #1 check("hold.edge1", bus.core_reset, 1);
    @(posedge clock); #1 check("hold.edge2", bus.core_reset, 0);
    check("idle.running", bus.running, 0);
    check("idle.done", bus.done, 0);

    // Plain run of 100 cycles; done must stay sticky.
    start_run(100);
    wait_done(300, rc);
    check("b100.run_cycles", rc, 100);
    check("b100.count", bus.cycle_count, 100);
    check("b100.halted", bus.halted, 0);
    repeat (5) @(negedge clock);
    check("b100.sticky", bus.done, 1);
    restart("r1");

    // Pause for 5 sampled cycles once 4 cycles have been counted.
    start_run(10);
    wait_count(4, 50);
    bus.pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("pause.frozen", bus.cycle_count, 4);
    end
    bus.pause = 1'b0;
    wait_done(100, rc);
    check("pause.count", bus.cycle_count, 10);
    check("pause.halted", bus.halted, 0);
`ifdef RUN_CTRL_PAUSE_COUNT_EN
    check("pause.pause_count", bus.pause_count, 5);
`endif
    restart("r2");

    // Early halt in the 7th RUN cycle; start is ignored mid-run.
    start_run(50);
    @(negedge clock); bus.start = 1'b1;
    @(negedge clock); bus.start = 1'b0;
    wait_count(6, 50);
    bus.halt_req = 1'b1;
    @(negedge clock); bus.halt_req = 1'b0;
    check("halt.done", bus.done, 1);
    check("halt.halted", bus.halted, 1);
    check("halt.count", bus.cycle_count, 7);
    restart("r3");

    // Zero budget goes straight to DONE.
    start_run(0);
    check("b0.done", bus.done, 1);
    check("b0.count", bus.cycle_count, 0);
    check("b0.running", bus.running, 0);
    restart("r4");

    // Halt coincident with budget exhaustion.
    start_run(3);
    wait_count(2, 20);
    bus.halt_req = 1'b1;
    @(negedge clock); bus.halt_req = 1'b0;
    check("tie.halted", bus.halted, 1);
    check("tie.count", bus.cycle_count, 3);
    restart("r5");

    // Halt while paused.
    start_run(20);
    wait_count(2, 20);
    bus.pause = 1'b1;
    repeat (2) @(negedge clock);
    bus.halt_req = 1'b1;
    @(negedge clock); bus.halt_req = 1'b0; bus.pause = 1'b0;
    check("phalt.done", bus.done, 1);
    check("phalt.halted", bus.halted, 1);
    check("phalt.count", bus.cycle_count, 2);
    restart("r6");

    // Asynchronous reset in the middle of a run.
    start_run(30);
    repeat (5) @(negedge clock);
    #2 reset = 1'b1;
    #1 check_reset_values("midreset");
    @(negedge clock); reset = 1'b0;
    repeat (3) @(negedge clock);
    check("midreset.idle", bus.core_reset, 0);
    start_run(2);
    wait_done(20, rc);
    check("post.count", bus.cycle_count, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
